// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit direction counters and mispredict redirect
// Optional BTB_STATS_EN adds saturating lookup/hit/mispredict counters.
module branch_target_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iFetchPC,
  input  logic        iFetchValid,
  output logic        oPredTaken,
  output logic [31:0] oPredTarget,
  input  logic        iResValid,
  input  logic [31:0] iResPC,
  input  logic        iResTaken,
  input  logic [31:0] iResTarget,
  input  logic        iResPredTaken,
  input  logic [31:0] iResPredTarget,
  output logic        oMispredict,
  output logic [31:0] oCorrectPC,
  output logic [31:0] oStatLookups,
  output logic [31:0] oStatHits,
  output logic [31:0] oStatMispredicts
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [TAGW-1:0]    tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [IDX-1:0]  fetch_idx, res_idx;
  logic [TAGW-1:0] fetch_tag, res_tag;
  logic            fetch_hit, res_hit;

  assign fetch_idx = iFetchPC[IDX+1:2];
  assign fetch_tag = iFetchPC[31:IDX+2];
  assign res_idx   = iResPC[IDX+1:2];
  assign res_tag   = iResPC[31:IDX+2];

  assign fetch_hit = iFetchValid & valid_q[fetch_idx] & (tag_q[fetch_idx] == fetch_tag);
  assign res_hit   = valid_q[res_idx] & (tag_q[res_idx] == res_tag);

  always_comb begin
    oMispredict = 1'b0;
    oCorrectPC  = 32'd0;
    if (iResValid) begin
      oMispredict = (iResPredTaken != iResTaken) |
                    (iResTaken & iResPredTaken & (iResPredTarget != iResTarget));
    end
    if (oMispredict) begin
      oCorrectPC = iResTaken ? iResTarget : (iResPC + 32'd4);
    end
  end

  // The PC register favours the predicted redirect, so suppress it under a mispredict.
  assign oPredTaken  = fetch_hit & ctr_q[fetch_idx][1] & ~oMispredict;
  assign oPredTarget = fetch_hit ? target_q[fetch_idx] : 32'd0;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (iResValid) begin
      if (res_hit) begin
        if (iResTaken) begin
          target_d[res_idx] = iResTarget;
          if (ctr_q[res_idx] != 2'b11) ctr_d[res_idx] = ctr_q[res_idx] + 2'b01;
        end else if (ctr_q[res_idx] != 2'b00) begin
          ctr_d[res_idx] = ctr_q[res_idx] - 2'b01;
        end
      end else if (iResTaken) begin
        valid_d[res_idx]  = 1'b1;
        tag_d[res_idx]    = res_tag;
        target_d[res_idx] = iResTarget;
        ctr_d[res_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q, lookups_d;
  logic [31:0] hits_q, hits_d;
  logic [31:0] mispred_q, mispred_d;

  always_comb begin
    lookups_d = lookups_q;
    hits_d    = hits_q;
    mispred_d = mispred_q;
    if (iFetchValid && lookups_q != 32'hFFFF_FFFF) lookups_d = lookups_q + 32'd1;
    if (oPredTaken  && hits_q    != 32'hFFFF_FFFF) hits_d    = hits_q + 32'd1;
    if (oMispredict && mispred_q != 32'hFFFF_FFFF) mispred_d = mispred_q + 32'd1;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      lookups_q <= 32'd0;
      hits_q    <= 32'd0;
      mispred_q <= 32'd0;
    end else begin
      lookups_q <= lookups_d;
      hits_q    <= hits_d;
      mispred_q <= mispred_d;
    end
  end

  assign oStatLookups     = lookups_q;
  assign oStatHits        = hits_q;
  assign oStatMispredicts = mispred_q;
`else
  assign oStatLookups     = 32'd0;
  assign oStatHits        = 32'd0;
  assign oStatMispredicts = 32'd0;
`endif

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Fetch-stage branch target buffer with 2-bit saturating direction counters. Each cycle it looks up the current fetch PC and, on a predicted-taken hit, drives the predicted-redirect pair (taken flag + target) into the PC register. It also receives resolved branches from execute, updates its table, and generates the mispredict redirect pair (flag + corrected PC) back to the PC register.

## Interface
Parameters:
- ENTRIES, 16, table depth; power of two, 4..256; IDX = log2(ENTRIES).

Ports:
- iClk  in  1  clock
- iRst  in  1  reset, asynchronous, active-high
- iFetchPC  in  32  current fetch PC (PC register output)
- iFetchValid  in  1  fetch slot valid; gates lookup and stats
- oPredTaken  out  1  predicted-taken redirect to PC register (priority input there)
- oPredTarget  out  32  predicted target
- iResValid  in  1  execute has resolved a control-flow instruction this cycle
- iResPC  in  32  PC of resolved instruction
- iResTaken  in  1  actual direction
- iResTarget  in  32  actual taken target
- iResPredTaken  in  1  prediction carried down the pipe for this instruction
- iResPredTarget  in  32  predicted target carried down the pipe
- oMispredict  out  1  mispredict redirect to PC register
- oCorrectPC  out  32  corrected fetch PC
- oStatLookups  out  32  fetch lookups counted
- oStatHits  out  32  predicted-taken hits counted
- oStatMispredicts  out  32  mispredicts counted

## Operation
- Entry fields: valid, tag = PC[31:IDX+2], target[31:0], ctr[1:0]. Index = PC[IDX+1:2]; PC[1:0] ignored.
- Lookup (combinational): hit = iFetchValid & valid[idx] & tag match. oPredTaken = hit & ctr[1] & ~oMispredict. oPredTarget = target[idx] when hit, else 0.
- Mispredict (combinational): active only when iResValid is high. It asserts when iResPredTaken != iResTaken, or when both are taken and iResPredTarget != iResTarget.
- oCorrectPC = iResTarget if iResTaken, else iResPC + 4 (mod 2^32). It is 0 when oMispredict = 0.
- oPredTaken is forced low while oMispredict is high. The PC register gives the predicted redirect priority, so the mispredict redirect would otherwise be lost.
- Update on a clock edge when iResValid is high, indexing by iResPC:
  - Hit, taken: ctr saturating-increment (max 3); target <= iResTarget.
  - Hit, not taken: ctr saturating-decrement (min 0); target unchanged.
  - Miss, taken: allocate and overwrite. valid = 1, tag, target <= iResTarget, ctr = 2'b10.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. The new state is visible the next cycle.

## Timing
- Lookup and mispredict paths have 0-cycle latency (combinational). Table updates take effect 1 cycle after the resolving edge.
- Reset (async, immediate):
  - All valid = 0, ctr = 2'b01, targets = 0.
  - Stats = 0.
  - Outputs follow combinationally: oPredTaken = 0, oPredTarget = 0. With iResValid = 0, oMispredict = 0 and oCorrectPC = 0.
- Reset asserted mid-update: the update is discarded. The table is fully invalid on the first edge after reset deasserts.
- Wrap-around: iResPC = 0xFFFF_FFFC with not-taken gives oCorrectPC = 0x0000_0000.

## Configuration
- BTB_STATS_EN defined: three 32-bit counters, each saturating at 0xFFFF_FFFF.
  - oStatLookups increments each cycle iFetchValid = 1.
  - oStatHits increments each cycle oPredTaken = 1.
  - oStatMispredicts increments each cycle oMispredict = 1.
- BTB_STATS_EN undefined: no counter flops. The three stat outputs are tied to 0. Ports are always present.

## Test plan
- Cold miss, then allocation:
  - Reset, then fetch 0x100 -> oPredTaken = 0.
  - Resolve 0x100 taken to 0x200 with predTaken = 0 -> oMispredict = 1, oCorrectPC = 0x200.
  - Next cycle, fetch 0x100 -> oPredTaken = 1, oPredTarget = 0x200.
- Counter hysteresis on the allocated 0x100 entry (ctr = 2):
  - Resolve not-taken once -> ctr = 1, so fetch 0x100 gives oPredTaken = 0.
  - Resolve taken twice -> ctr = 3.
  - Resolve not-taken once -> ctr = 2, still predicts taken.
- Target mismatch: resolve 0x100 taken to 0x300 with predTaken = 1, predTarget = 0x200 -> oMispredict = 1, oCorrectPC = 0x300, stored target becomes 0x300.
- Priority and aliasing, ENTRIES = 16:
  - Same cycle: fetch hits taken, and a mispredict resolves -> oPredTaken = 0, oMispredict = 1.
  - 0x100 and 0x140 share index 0 with different tags. Allocating 0x140 evicts 0x100, so fetch 0x100 gives oPredTaken = 0.
- Wrap and reset:
  - Resolve 0xFFFF_FFFC not-taken with predTaken = 1 -> oCorrectPC = 0x0.
  - Assert iRst mid-run -> every entry misses, and stats read 0.
- Stats with BTB_STATS_EN: 10 fetch cycles, 3 taken hits, 2 mispredicts -> oStatLookups = 10, oStatHits = 3, oStatMispredicts = 2.
- Stats without BTB_STATS_EN: the same sequence -> all three stat outputs read 0.
